// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the ALU control unit (master) and shift_sequencer (slave).
// Requests are accepted only while busy_o is low; done_o pulses once per completed result.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] data_i;
  logic [SHW-1:0]   shamt_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, data_i, shamt_i, abort_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, data_i, shamt_i, abort_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA shifter, up to STEP bits per cycle; done_o ceil(shamt/STEP)+1 cycles after start.
// Requests are dropped while busy_o is high. SHIFT_ROTR_EN turns op 2'b10 into ROTR; otherwise it is SLL.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int SHW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [SHW-1:0]   rem_q;
  logic [SHW-1:0]   rem_d;
  logic [SHW-1:0]   shift_k;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  // SRA keeps the MSB in place, so the MSB of work always equals the latched sign bit.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] w, input logic [1:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      2'b01:   r = {1'b0, w[WIDTH-1:1]};
      2'b11:   r = {w[WIDTH-1], w[WIDTH-1:1]};
`ifdef SHIFT_ROTR_EN
      2'b10:   r = {w[0], w[WIDTH-1:1]};
`endif
      default: r = {w[WIDTH-2:0], 1'b0};
    endcase
    return r;
  endfunction

  always_comb begin
    shift_k = (rem_q < STEP_W) ? rem_q : STEP_W;
    work_d  = work_q;
    for (int i = 0; i < STEP; i++) begin
      if (SHW'(i) < shift_k) work_d = shift1(work_d, op_q);
    end
    rem_d = rem_q - shift_k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            work_q <= bus.data_i;
            op_q   <= bus.op_i;
            rem_q  <= bus.shamt_i;
            if (bus.shamt_i == '0) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= bus.data_i;
            end else begin
              state_q <= SHIFT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          // Abort wins even on the cycle that would have completed.
          if (bus.abort_i) begin
            state_q <= IDLE;
          end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            if (rem_d == '0) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= work_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (state_q == SHIFT);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random checks of shift_sequencer (WIDTH=32, STEP=2) against a behavioural shift model.
module tb_shift_sequencer;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .STEP(2), .SHW(SHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, s};
    case (op)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b11: return $signed(d) >>> s;
      default: begin
`ifdef SHIFT_ROTR_EN
        if (s == 5'd0) return d;
        return (d >> s) | (d << inv);
`else
        return d << s;
`endif
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] s);
    return (s == 5'd0) ? 1 : (int'(s) + 1) / 2 + 1;
  endfunction

  // Called at posedge+1: drives one request for the upcoming edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s, input bit push);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.data_i  = d;
    bus.shamt_i = s;
    if (push) exp_q.push_back(model(op, d, s));
  endtask

  // Waits for done_o, checking latency and that result_o holds the previous value meanwhile.
  task automatic wait_done(input string tag, input int exp_lat, output bit saw_busy);
    int lat;
    logic [31:0] exp_res;
    lat = 0;
    saw_busy = 1'b0;
    do begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      lat++;
      if (bus.busy_o) saw_busy = 1'b1;
      if (bus.done_o !== 1'b1 && bus.result_o !== last_res)
        check({tag, "_hold"}, bus.result_o, last_res);
    end while (bus.done_o !== 1'b1 && lat < 64);
    check({tag, "_done"}, 32'(bus.done_o), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_result"}, bus.result_o, exp_res);
    last_res = exp_res;
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_low"}, 32'(bus.done_o), 32'd0);
    check({tag, "_busy_low"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    bit sb;
    start_op(op, d, s, 1'b1);
    wait_done(tag, lat_of(s), sb);
    check({tag, "_busy_seen"}, 32'(sb), (s == 5'd0) ? 32'd0 : 32'd1);
    pulse_end(tag);
  endtask

  initial begin
    bit sb;
    int done_cnt;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.data_i  = '0;
    bus.shamt_i = '0;
    bus.abort_i = 1'b0;
    last_res    = '0;
    #1;
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("sll_1_2", 2'b00, 32'h0000_0001, 5'd2);
    run_op("sra_31", 2'b11, 32'h8000_0000, 5'd31);
    run_op("srl_31", 2'b01, 32'h8000_0000, 5'd31);
    run_op("shamt0", 2'b00, 32'hDEAD_BEEF, 5'd0);
    run_op("rotr_1", 2'b10, 32'h0000_0001, 5'd1);

    // A second start two cycles into a busy operation must be dropped.
    start_op(2'b00, 32'h0000_0001, 5'd8, 1'b1);
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(posedge clk); #1 start_op(2'b01, 32'hFFFF_FFFF, 5'd3, 1'b0);
    wait_done("ignored_start", 3, sb);
    pulse_end("ignored_start");

    // Back-to-back: second request issued in the DONE cycle of the first.
    start_op(2'b00, 32'h0000_0003, 5'd4, 1'b1);
    wait_done("b2b_first", 3, sb);
    start_op(2'b01, 32'h0000_00F0, 5'd4, 1'b1);
    wait_done("b2b_second", 3, sb);
    pulse_end("b2b_second");

    // Abort in cycle 3 of a 16-bit shift.
    start_op(2'b01, 32'hFFFF_0000, 5'd16, 1'b0);
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.abort_i = 1'b1;
    @(posedge clk); #1 bus.abort_i = 1'b0;
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_result", bus.result_o, last_res);
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // Abort asserted with a start while idle is ignored.
    bus.abort_i = 1'b1;
    run_op("abort_idle", 2'b11, 32'h8000_00F0, 5'd5);

    // Asynchronous reset mid-shift clears outputs without waiting for an edge.
    start_op(2'b00, 32'h0000_0005, 5'd20, 1'b0);
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    check("rst_mid_done", 32'(bus.done_o), 32'd0);
    check("rst_mid_result", bus.result_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    last_res = '0;
    run_op("after_rst", 2'b01, 32'hF000_000F, 5'd7);

    for (int n = 0; n < 8; n++) begin
      run_op("random", 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
